// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN shift-and-add multiplier: one add-and-shift step per clock on a single ripple adder.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands finish in one cycle with a zero product.

module n_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign {cout, sum} = total;
endmodule

module shift_add_multiplier #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] Product
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   add_b;
    logic [N-1:0]   add_sum;
    logic           add_cout;

`ifdef MUL_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (A == '0) || (B == '0);
`endif

    assign add_b = acc[0] ? mcand : '0;

    n_bit_adder #(.N(N)) u_adder (
        .a    (acc[2*N-1:N]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry out becomes the new MSB; dropping it breaks operands >= 2^(N-1).
    assign acc_next = {add_cout, add_sum, acc[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MUL_ZERO_SKIP_EN
                    state_next = zero_op ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            Product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        acc   <= {{N{1'b0}}, B};
                        cnt   <= CNT_LOAD;
`ifdef MUL_ZERO_SKIP_EN
                        if (zero_op) begin
                            Product <= '0;
                        end
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        Product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=16): scoreboard of A*B products plus timing checks.
module tb_shift_add_multiplier;
    localparam int N = 16;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZERO_DONE_EDGE = 0;
    localparam int ZERO_BUSY_CNT  = 1;
`else
    localparam int ZERO_DONE_EDGE = N;
    localparam int ZERO_BUSY_CNT  = N + 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] Product;

    logic [2*N-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Edges are counted from the one that samples start (edge 0); samples are taken 1 time unit after each edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit noisy,
                          output logic [2*N-1:0] prod, output int done_edge,
                          output int busy_cnt, output int done_cnt);
        logic [2*N-1:0] e;
        e = a * b;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        exp_q.push_back(e);
        prod = '0;
        done_edge = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 4 * N; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = k;
                    prod = Product;
                end
            end
            if (noisy) begin
                if (busy && !done) begin
                    start = 1'b1;
                    A = N'($urandom);
                    B = N'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            if (!busy) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
        n_checks++;
        if (Product !== '0) begin n_fail++; $display("FAIL reset_product: got %h, expected 0", Product); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic [2*N-1:0] prod, e;
        int de, bc, dc;
        run_op(16'd3, 16'd5, 1'b0, prod, de, bc, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (prod !== e) begin n_fail++; $display("FAIL basic_product: got %h, expected %h", prod, e); end
        n_checks++;
        if (de != N) begin n_fail++; $display("FAIL basic_done_edge: got %0d, expected %0d", de, N); end
        n_checks++;
        if (bc != N + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected %0d", bc, N + 1); end
        n_checks++;
        if (dc != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d, expected 1", dc); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (Product !== e) begin n_fail++; $display("FAIL basic_product_hold: got %h, expected %h", Product, e); end
    endtask

    task automatic test_cout();
        logic [N-1:0] ta[2] = '{16'hFFFF, 16'h8000};
        logic [N-1:0] tb[2] = '{16'hFFFF, 16'h0002};
        logic [2*N-1:0] prod, e;
        int de, bc, dc;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], tb[i], 1'b0, prod, de, bc, dc);
            e = exp_q.pop_front();
            n_checks++;
            if (prod !== e) begin n_fail++; $display("FAIL cout_product[%0d]: got %h, expected %h", i, prod, e); end
            n_checks++;
            if (de != N) begin n_fail++; $display("FAIL cout_done_edge[%0d]: got %0d, expected %0d", i, de, N); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] p1, p2, e1, e2;
        int first_done, second_done;
        p1 = '0;
        p2 = '0;
        first_done = -1;
        second_done = -1;
        @(negedge clk);
        A = 16'd7;
        B = 16'd9;
        start = 1'b1;
        exp_q.push_back(32'd63);
        @(posedge clk);
        #1;
        A = 16'd11;
        B = 16'd13;
        for (int k = 1; k <= 4 * N; k++) begin
            @(posedge clk);
            #1;
            if (done && k <= N + 1 && first_done < 0) begin first_done = k; p1 = Product; end
            if (done && k > N + 1 && second_done < 0) begin second_done = k; p2 = Product; end
            if (k == N + 1) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy got %b, expected 0", busy); end
                exp_q.push_back(32'd143);
            end
            if (k == N + 2) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy got %b, expected 1", busy); end
                start = 1'b0;
            end
            if (second_done >= 0 && !busy) break;
        end
        start = 1'b0;
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n_checks++;
        if (p1 !== e1) begin n_fail++; $display("FAIL b2b_first_product: got %h, expected %h", p1, e1); end
        n_checks++;
        if (first_done != N) begin n_fail++; $display("FAIL b2b_first_done_edge: got %0d, expected %0d", first_done, N); end
        n_checks++;
        if (p2 !== e2) begin n_fail++; $display("FAIL b2b_second_product: got %h, expected %h", p2, e2); end
        n_checks++;
        if (second_done != 2 * N + 2) begin n_fail++; $display("FAIL b2b_second_done_edge: got %0d, expected %0d", second_done, 2 * N + 2); end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] prod, e;
        int de, bc, dc, stray;
        @(negedge clk);
        A = 16'h1234;
        B = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b, expected 0", done); end
        n_checks++;
        if (Product !== '0) begin n_fail++; $display("FAIL midreset_product: got %h, expected 0", Product); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 2 * N; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin n_fail++; $display("FAIL midreset_no_done: busy/done cycles got %0d, expected 0", stray); end
        run_op(16'h1234, 16'h5678, 1'b0, prod, de, bc, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (prod !== e || prod !== 32'h06260060) begin
            n_fail++; $display("FAIL midreset_fresh_product: got %h, expected %h", prod, e);
        end
    endtask

    task automatic test_zero();
        logic [N-1:0] ta[2] = '{16'h0000, 16'h1357};
        logic [N-1:0] tb[2] = '{16'hABCD, 16'h0000};
        logic [2*N-1:0] prod, e;
        int de, bc, dc;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], tb[i], 1'b0, prod, de, bc, dc);
            e = exp_q.pop_front();
            n_checks++;
            if (prod !== e) begin n_fail++; $display("FAIL zero_product[%0d]: got %h, expected %h", i, prod, e); end
            n_checks++;
            if (de != ZERO_DONE_EDGE) begin n_fail++; $display("FAIL zero_done_edge[%0d]: got %0d, expected %0d", i, de, ZERO_DONE_EDGE); end
            n_checks++;
            if (bc != ZERO_BUSY_CNT) begin n_fail++; $display("FAIL zero_busy_cycles[%0d]: got %0d, expected %0d", i, bc, ZERO_BUSY_CNT); end
        end
    endtask

    task automatic test_random();
        logic [2*N-1:0] prod, e;
        logic [N-1:0] a, b;
        int de, bc, dc;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
            if ($urandom_range(0, 15) == 0) b = 16'h8000 | N'($urandom_range(0, 255));
            run_op(a, b, ($urandom_range(0, 1) == 1), prod, de, bc, dc);
            e = exp_q.pop_front();
            n_checks++;
            if (prod !== e || dc != 1) begin
                n_fail++;
                $display("FAIL random_op[%0d] %h*%h: got %h (done pulses %0d), expected %h (1 pulse)", i, a, b, prod, dc, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cout();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
